// File: rtl/snake_move_scheduler.sv
// Snake game-flow controller: game FSM, move tick, direction arbitration, step request/response.
// Latency: step_o rises one clock after the tick terminal count; outcome of done_i visible one clock later.
// Backpressure: each step waits in WAIT for done_i (bounded by ACK_TIMEOUT); no new step is issued meanwhile.
module snake_move_scheduler #(
    parameter int TICK_DIV    = 15_000_000,
    parameter int INIT_LEN    = 3,
    parameter int MAX_LEN     = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       BtnU,
    input  logic       BtnR,
    input  logic       BtnD,
    input  logic       BtnL,
    input  logic       done_i,
    input  logic       collide_i,
    input  logic       ate_i,
    output logic       step_o,
    output logic       grow_o,
    output logic [1:0] dir_o,
    output logic [7:0] length_o,
    output logic       q_I,
    output logic       q_Run,
    output logic       q_Lose,
    output logic       q_Win
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TO_W  = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [7:0]       LEN_INIT = 8'(INIT_LEN);
    localparam logic [7:0]       LEN_MAX  = 8'(MAX_LEN);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_RUN  = 3'd1,
        S_STEP = 3'd2,
        S_WAIT = 3'd3,
        S_LOSE = 3'd4,
        S_WIN  = 3'd5
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [1:0]       r_dir;
    logic [1:0]       r_pend;
    logic             r_armed;
    logic             r_grow_pend;
    logic [7:0]       r_len;
    logic             r_step;
    logic             r_grow;
    logic             r_q_i;
    logic             r_q_run;
    logic             r_q_lose;
    logic             r_q_win;

    state_t           w_next;
    logic [CNT_W-1:0] w_cnt;
    logic [TO_W-1:0]  w_to_cnt;
    logic [1:0]       w_dir;
    logic [1:0]       w_pend;
    logic             w_armed;
    logic             w_grow_pend;
    logic [7:0]       w_len;
    logic             w_step;
    logic             w_grow;

    logic             w_btn_any;
    logic [1:0]       w_btn_dir;
    logic             w_live;
    logic             w_reverse;
    logic             w_accept;

    // Button arbitration: pick the highest-priority press (U > R > D > L), then
    // drop it if it would reverse the committed direction once the game is armed.
    always_comb begin
        w_btn_any = BtnU | BtnR | BtnD | BtnL;
        w_btn_dir = DIR_LEFT;
        if (BtnU) begin
            w_btn_dir = DIR_UP;
        end else if (BtnR) begin
            w_btn_dir = DIR_RIGHT;
        end else if (BtnD) begin
            w_btn_dir = DIR_DOWN;
        end
        w_live    = (r_state == S_RUN) || (r_state == S_STEP) || (r_state == S_WAIT);
        // Opposite directions differ only in the MSB of the encoding.
        w_reverse = (w_btn_dir == (r_dir ^ 2'b10));
        w_accept  = w_live && w_btn_any && (!r_armed || !w_reverse);
    end

    // Next-state and next-value logic for the game FSM and its datapath registers.
    always_comb begin
        w_next      = r_state;
        w_cnt       = r_cnt;
        w_to_cnt    = r_to_cnt;
        w_dir       = r_dir;
        w_pend      = r_pend;
        w_armed     = r_armed;
        w_grow_pend = r_grow_pend;
        w_len       = r_len;
        w_step      = 1'b0;
        w_grow      = 1'b0;

        // A press on the terminal-count cycle lands in pending only; dir_o takes
        // the old pending value below, so that press applies to the following step.
        if (w_accept) begin
            w_pend  = w_btn_dir;
            w_armed = 1'b1;
        end

        case (r_state)
            S_INIT: begin
                w_next = S_RUN;
            end
            S_RUN: begin
                // The tick only runs after the first direction press.
                if (r_armed) begin
                    if (r_cnt == CNT_LAST) begin
                        w_next      = S_STEP;
                        w_cnt       = '0;
                        w_dir       = r_pend;
                        w_step      = 1'b1;
                        w_grow      = r_grow_pend;
                        w_grow_pend = 1'b0;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_STEP: begin
                w_next   = S_WAIT;
                w_to_cnt = '0;
            end
            S_WAIT: begin
                if (done_i) begin
                    w_to_cnt = '0;
                    if (collide_i) begin
                        w_next = S_LOSE;
                    end else if (ate_i) begin
                        w_grow_pend = 1'b1;
                        if (r_len >= (LEN_MAX - 8'd1)) begin
                            w_len  = LEN_MAX;
                            w_next = S_WIN;
                        end else begin
                            w_len  = r_len + 8'd1;
                            w_next = S_RUN;
                        end
                    end else begin
                        w_next = S_RUN;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    // Datapath never answered: treat as a loss.
                    w_to_cnt = '0;
                    w_next   = S_LOSE;
                end else begin
                    w_to_cnt = r_to_cnt + TO_W'(1);
                end
            end
            default: begin
                // LOSE and WIN hold until Reset.
                w_next = r_state;
            end
        endcase
    end

    // State register and all registered outputs; Reset overrides any input in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_to_cnt    <= '0;
            r_dir       <= DIR_RIGHT;
            r_pend      <= DIR_RIGHT;
            r_armed     <= 1'b0;
            r_grow_pend <= 1'b0;
            r_len       <= LEN_INIT;
            r_step      <= 1'b0;
            r_grow      <= 1'b0;
            r_q_i       <= 1'b1;
            r_q_run     <= 1'b0;
            r_q_lose    <= 1'b0;
            r_q_win     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt;
            r_to_cnt    <= w_to_cnt;
            r_dir       <= w_dir;
            r_pend      <= w_pend;
            r_armed     <= w_armed;
            r_grow_pend <= w_grow_pend;
            r_len       <= w_len;
            r_step      <= w_step;
            r_grow      <= w_grow;
            r_q_i       <= (w_next == S_INIT);
            r_q_run     <= (w_next == S_RUN) || (w_next == S_STEP) || (w_next == S_WAIT);
            r_q_lose    <= (w_next == S_LOSE);
            r_q_win     <= (w_next == S_WIN);
        end
    end

    assign step_o   = r_step;
    assign grow_o   = r_grow;
    assign dir_o    = r_dir;
    assign length_o = r_len;
    assign q_I      = r_q_i;
    assign q_Run    = r_q_run;
    assign q_Lose   = r_q_lose;
    assign q_Win    = r_q_win;

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Bench for snake_move_scheduler: directed scenarios plus a randomized run against a reference model.
// The datapath is emulated by a responder that answers each step after a programmable latency.
// All inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_snake_move_scheduler;

    localparam int TD = 8;
    localparam int IL = 3;
    localparam int ML = 5;
    localparam int AT = 20;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       BtnU = 1'b0, BtnR = 1'b0, BtnD = 1'b0, BtnL = 1'b0;
    logic       done_i = 1'b0, collide_i = 1'b0, ate_i = 1'b0;
    logic       step_o, grow_o;
    logic [1:0] dir_o;
    logic [7:0] length_o;
    logic       q_I, q_Run, q_Lose, q_Win;

    int n_pass  = 0;
    int n_total = 0;

    // Datapath responder controls.
    bit resp_en  = 1'b1;
    int resp_lat = 1;
    bit resp_ate = 1'b0;
    bit resp_col = 1'b0;
    int resp_cnt = 0;
    bit spur_en  = 1'b0;

    // Reference model: game phase plus the quantities the rules talk about.
    localparam int P_INIT = 0, P_MOVE = 1, P_STEP = 2, P_WAIT = 3, P_LOSE = 4, P_WIN = 5;
    int         m_phase   = P_INIT;
    int         m_elapsed = 0;
    int         m_waited  = 0;
    bit         m_armed   = 1'b0;
    logic [1:0] m_dir     = 2'b01;
    logic [1:0] m_pend    = 2'b01;
    int         m_len     = IL;
    bit         m_growp   = 1'b0;
    bit         m_step    = 1'b0;
    bit         m_grow    = 1'b0;

    snake_move_scheduler #(
        .TICK_DIV   (TD),
        .INIT_LEN   (IL),
        .MAX_LEN    (ML),
        .ACK_TIMEOUT(AT)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .BtnU     (BtnU),
        .BtnR     (BtnR),
        .BtnD     (BtnD),
        .BtnL     (BtnL),
        .done_i   (done_i),
        .collide_i(collide_i),
        .ate_i    (ate_i),
        .step_o   (step_o),
        .grow_o   (grow_o),
        .dir_o    (dir_o),
        .length_o (length_o),
        .q_I      (q_I),
        .q_Run    (q_Run),
        .q_Lose   (q_Lose),
        .q_Win    (q_Win)
    );

    always #5 Clk = ~Clk;

    // Advance the model across one clock edge given the inputs currently applied.
    task automatic model_update();
        int         b;
        logic [1:0] od;
        logic [1:0] op;
        bit         oa;
        if (Reset) begin
            m_phase = P_INIT; m_elapsed = 0; m_waited = 0; m_armed = 1'b0;
            m_dir = 2'b01; m_pend = 2'b01; m_len = IL; m_growp = 1'b0;
            m_step = 1'b0; m_grow = 1'b0;
        end else begin
            od = m_dir; op = m_pend; oa = m_armed;
            m_step = 1'b0; m_grow = 1'b0;
            if ((m_phase == P_MOVE || m_phase == P_STEP || m_phase == P_WAIT) &&
                (BtnU || BtnR || BtnD || BtnL)) begin
                b = BtnU ? 0 : BtnR ? 1 : BtnD ? 2 : 3;
                if (!oa || ((b + 2) % 4) != int'(od)) begin
                    m_pend  = 2'(b);
                    m_armed = 1'b1;
                end
            end
            case (m_phase)
                P_INIT: m_phase = P_MOVE;
                P_MOVE: begin
                    if (oa) begin
                        if (m_elapsed == TD - 1) begin
                            m_phase = P_STEP; m_elapsed = 0; m_dir = op;
                            m_step = 1'b1; m_grow = m_growp; m_growp = 1'b0;
                        end else begin
                            m_elapsed++;
                        end
                    end
                end
                P_STEP: begin m_phase = P_WAIT; m_waited = 0; end
                P_WAIT: begin
                    if (done_i) begin
                        if (collide_i) m_phase = P_LOSE;
                        else if (ate_i) begin
                            m_len   = (m_len + 1 > ML) ? ML : m_len + 1;
                            m_growp = 1'b1;
                            m_phase = (m_len == ML) ? P_WIN : P_MOVE;
                        end else m_phase = P_MOVE;
                    end else begin
                        m_waited++;
                        if (m_waited == AT) m_phase = P_LOSE;
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [15:0] model_out();
        logic [3:0] f;
        f = {m_phase == P_INIT, (m_phase == P_MOVE || m_phase == P_STEP || m_phase == P_WAIT),
             m_phase == P_LOSE, m_phase == P_WIN};
        return {f, m_step, m_grow, m_dir, 8'(m_len)};
    endfunction

    // One clock: update model, take the edge, release button pulses, run the datapath responder.
    task automatic cyc();
        model_update();
        @(posedge Clk);
        #1;
        BtnU = 1'b0; BtnR = 1'b0; BtnD = 1'b0; BtnL = 1'b0;
        done_i = 1'b0; ate_i = 1'b0; collide_i = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                done_i = 1'b1; ate_i = resp_ate; collide_i = resp_col;
            end
        end
        if (resp_en && step_o) resp_cnt = resp_lat;
        if (spur_en && !done_i && $urandom_range(0, 19) == 0) begin
            done_i = 1'b1;
            ate_i = 1'($urandom_range(0, 1));
            collide_i = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic wait_step(input int limit, output int waited, output bit seen);
        seen = 1'b0; waited = 0;
        while (!seen && waited < limit) begin
            cyc();
            waited++;
            if (step_o) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        int w; bit seen;
        Reset = 1'b1; BtnR = 1'b1;
        cyc();
        Reset = 1'b0;
        n_total++;
        if ({q_I, q_Run, q_Lose, q_Win, step_o, grow_o, dir_o, length_o} !== {4'b1000, 2'b00, 2'b01, 8'd3})
            $display("FAIL reset_values got flags=%b step=%b grow=%b dir=%b len=%0d exp flags=1000 step=0 grow=0 dir=01 len=3",
                     {q_I, q_Run, q_Lose, q_Win}, step_o, grow_o, dir_o, length_o);
        else n_pass++;
        cyc();
        n_total++;
        if ({q_I, q_Run, q_Lose, q_Win} !== 4'b0100)
            $display("FAIL reset_to_run got flags=%b exp 0100", {q_I, q_Run, q_Lose, q_Win});
        else n_pass++;
        wait_step(10 * TD, w, seen);
        n_total++;
        if (seen !== 1'b0) $display("FAIL idle_no_step got step after %0d cycles exp none", w);
        else n_pass++;
    endtask

    task automatic test_period();
        int w; bit seen;
        resp_en = 1'b1; resp_lat = 1; resp_ate = 1'b0; resp_col = 1'b0;
        BtnR = 1'b1;
        cyc();
        wait_step(TD + 5, w, seen);
        n_total++;
        if (!seen || w != TD) $display("FAIL first_step_latency got seen=%b cycles=%0d exp cycles=%0d", seen, w, TD);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            wait_step(TD + 10, w, seen);
            n_total++;
            if (!seen || w != TD + 2 || dir_o !== 2'b01 || grow_o !== 1'b0)
                $display("FAIL step_period%0d got seen=%b cycles=%0d dir=%b grow=%b exp cycles=%0d dir=01 grow=0",
                         i, seen, w, dir_o, grow_o, TD + 2);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        int w; bit seen;
        cyc(); cyc();
        BtnU = 1'b1; BtnL = 1'b1;
        cyc();
        wait_step(TD + 10, w, seen);
        n_total++;
        if (!seen || dir_o !== 2'b00) $display("FAIL priority_UL got seen=%b dir=%b exp dir=00", seen, dir_o);
        else n_pass++;
        cyc(); cyc();
        BtnD = 1'b1;
        cyc();
        wait_step(TD + 10, w, seen);
        n_total++;
        if (!seen || dir_o !== 2'b00) $display("FAIL reverse_discard got seen=%b dir=%b exp dir=00", seen, dir_o);
        else n_pass++;
        // Press on the terminal-count cycle: not used by this step, used by the next.
        repeat (9) cyc();
        BtnR = 1'b1;
        cyc();
        n_total++;
        if (step_o !== 1'b1 || dir_o !== 2'b00)
            $display("FAIL terminal_press_step got step=%b dir=%b exp step=1 dir=00", step_o, dir_o);
        else n_pass++;
        wait_step(TD + 10, w, seen);
        n_total++;
        if (!seen || dir_o !== 2'b01) $display("FAIL terminal_press_next got seen=%b dir=%b exp dir=01", seen, dir_o);
        else n_pass++;
    endtask

    task automatic test_grow_win();
        int w; bit seen;
        resp_ate = 1'b1;
        cyc();
        resp_ate = 1'b0;
        cyc();
        n_total++;
        if (length_o !== 8'd4 || q_Run !== 1'b1) $display("FAIL ate_len got len=%0d run=%b exp len=4 run=1", length_o, q_Run);
        else n_pass++;
        wait_step(TD + 10, w, seen);
        n_total++;
        if (!seen || grow_o !== 1'b1) $display("FAIL grow_step got seen=%b grow=%b exp grow=1", seen, grow_o);
        else n_pass++;
        wait_step(TD + 10, w, seen);
        n_total++;
        if (!seen || grow_o !== 1'b0) $display("FAIL grow_clear got seen=%b grow=%b exp grow=0", seen, grow_o);
        else n_pass++;
        resp_ate = 1'b1;
        cyc();
        resp_ate = 1'b0;
        cyc();
        n_total++;
        if (length_o !== 8'd5 || {q_I, q_Run, q_Lose, q_Win} !== 4'b0001)
            $display("FAIL win got len=%0d flags=%b exp len=5 flags=0001", length_o, {q_I, q_Run, q_Lose, q_Win});
        else n_pass++;
        BtnU = 1'b1;
        wait_step(3 * TD, w, seen);
        n_total++;
        if (seen || q_Win !== 1'b1) $display("FAIL win_hold got seen=%b win=%b exp seen=0 win=1", seen, q_Win);
        else n_pass++;
    endtask

    task automatic test_lose_collide();
        int w; bit seen;
        logic [3:0] mask;
        Reset = 1'b1; cyc(); Reset = 1'b0;
        resp_cnt = 0; resp_lat = 1; resp_en = 1'b1;
        cyc();
        BtnR = 1'b1;
        cyc();
        wait_step(TD + 5, w, seen);
        resp_col = 1'b1; resp_ate = 1'b1;
        cyc();
        resp_col = 1'b0; resp_ate = 1'b0;
        cyc();
        n_total++;
        if ({q_I, q_Run, q_Lose, q_Win} !== 4'b0010 || length_o !== 8'd3)
            $display("FAIL collide_lose got flags=%b len=%0d exp flags=0010 len=3", {q_I, q_Run, q_Lose, q_Win}, length_o);
        else n_pass++;
        seen = 1'b0;
        spur_en = 1'b1;
        for (int i = 0; i < 3 * TD; i++) begin
            mask = 4'($urandom_range(1, 15));
            {BtnU, BtnR, BtnD, BtnL} = mask;
            cyc();
            if (step_o) seen = 1'b1;
        end
        spur_en = 1'b0;
        n_total++;
        if (seen || q_Lose !== 1'b1 || dir_o !== 2'b01)
            $display("FAIL lose_hold got seen=%b lose=%b dir=%b exp seen=0 lose=1 dir=01", seen, q_Lose, dir_o);
        else n_pass++;
        Reset = 1'b1; cyc(); Reset = 1'b0;
        n_total++;
        if ({q_I, q_Run, q_Lose, q_Win} !== 4'b1000 || length_o !== 8'd3)
            $display("FAIL lose_reset got flags=%b len=%0d exp flags=1000 len=3", {q_I, q_Run, q_Lose, q_Win}, length_o);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int w; bit seen;
        cyc();
        resp_en = 1'b0;
        BtnL = 1'b1;
        cyc();
        wait_step(TD + 5, w, seen);
        n_total++;
        if (!seen || dir_o !== 2'b11) $display("FAIL first_press_left got seen=%b dir=%b exp dir=11", seen, dir_o);
        else n_pass++;
        repeat (AT) cyc();
        n_total++;
        if ({q_I, q_Run, q_Lose, q_Win} !== 4'b0100)
            $display("FAIL timeout_early got flags=%b exp 0100", {q_I, q_Run, q_Lose, q_Win});
        else n_pass++;
        cyc();
        n_total++;
        if ({q_I, q_Run, q_Lose, q_Win} !== 4'b0010)
            $display("FAIL timeout_lose got flags=%b exp 0010", {q_I, q_Run, q_Lose, q_Win});
        else n_pass++;
        resp_en = 1'b1;
    endtask

    task automatic test_reset_in_wait();
        int w; bit seen;
        Reset = 1'b1; cyc(); Reset = 1'b0;
        resp_cnt = 0;
        cyc();
        resp_en = 1'b1; resp_lat = 1; resp_ate = 1'b1;
        BtnD = 1'b1;
        cyc();
        wait_step(TD + 5, w, seen);
        resp_en = 1'b0;
        cyc();
        resp_ate = 1'b0;
        cyc();
        n_total++;
        if (length_o !== 8'd4) $display("FAIL rw_len got len=%0d exp 4", length_o);
        else n_pass++;
        wait_step(TD + 10, w, seen);
        n_total++;
        if (!seen || grow_o !== 1'b1 || dir_o !== 2'b10)
            $display("FAIL rw_grow got seen=%b grow=%b dir=%b exp grow=1 dir=10", seen, grow_o, dir_o);
        else n_pass++;
        repeat (3) cyc();
        Reset = 1'b1; done_i = 1'b1; ate_i = 1'b1;
        cyc();
        Reset = 1'b0;
        n_total++;
        if ({q_I, q_Run, q_Lose, q_Win, step_o, grow_o, dir_o, length_o} !== {4'b1000, 2'b00, 2'b01, 8'd3})
            $display("FAIL rw_reset got flags=%b step=%b grow=%b dir=%b len=%0d exp flags=1000 step=0 grow=0 dir=01 len=3",
                     {q_I, q_Run, q_Lose, q_Win}, step_o, grow_o, dir_o, length_o);
        else n_pass++;
        cyc();
        wait_step(3 * TD, w, seen);
        n_total++;
        if (seen || q_Run !== 1'b1) $display("FAIL rw_disarmed got seen=%b run=%b exp seen=0 run=1", seen, q_Run);
        else n_pass++;
        BtnU = 1'b1;
        cyc();
        resp_en = 1'b1;
        wait_step(TD + 5, w, seen);
        n_total++;
        if (!seen || grow_o !== 1'b0 || dir_o !== 2'b00)
            $display("FAIL rw_growpend_cleared got seen=%b grow=%b dir=%b exp grow=0 dir=00", seen, grow_o, dir_o);
        else n_pass++;
    endtask

    task automatic test_random();
        int         term_cnt = 0;
        logic [3:0] mask;
        logic [15:0] got_v, exp_v;
        resp_en = 1'b1; spur_en = 1'b1; resp_cnt = 0;
        Reset = 1'b1; cyc(); Reset = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                mask = 4'($urandom_range(1, 15));
                {BtnU, BtnR, BtnD, BtnL} = mask;
            end
            resp_lat = ($urandom_range(0, 15) == 0) ? AT + 3 : int'($urandom_range(1, 3));
            resp_ate = ($urandom_range(0, 5) == 0);
            resp_col = ($urandom_range(0, 30) == 0);
            if (q_Lose || q_Win) Reset = (term_cnt >= 6);
            else Reset = ($urandom_range(0, 299) == 0);
            term_cnt = (q_Lose || q_Win) ? term_cnt + 1 : 0;
            cyc();
            Reset = 1'b0;
            got_v = {q_I, q_Run, q_Lose, q_Win, step_o, grow_o, dir_o, length_o};
            exp_v = model_out();
            n_total++;
            if (got_v !== exp_v)
                $display("FAIL rand_cycle%0d got %b exp %b (flags,step,grow,dir,len)", i, got_v, exp_v);
            else n_pass++;
        end
        spur_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_period();
        test_priority();
        test_grow_win();
        test_lose_collide();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got sim time limit exp completion");
        $fatal(1);
    end

endmodule
